// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer valid/ready/data streams, the FIFO write port and the
// arbiter status outputs that connect a fifo_wr_arbiter to its environment.
//   req_valid  : per-producer "word offered" flags
//   req_data   : producer i's word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : per-producer "word accepted this cycle"
//   fifo_full  : FIFO full flag
//   fifo_wr_en : FIFO write enable
//   fifo_din   : FIFO write data
//   grant      : registered one-hot grant, zero when idle
//   busy       : arbiter is in a burst
// modport master : producers + FIFO side
// modport slave  : arbiter side
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin write-side arbiter sharing one synchronous FIFO between NUM_REQ
// producers. One producer is granted at a time for a burst of up to BURST_LEN
// words; its stream is muxed onto the FIFO write port. The grant moves to the
// next requester on the same edge as the last beat, so there is no bubble.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fifo_wr_arbiter_if.slave (producer streams, FIFO port, status)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                 state;
  logic [NUM_REQ-1:0]     grant_vec;
  logic                   busy_flag;
  logic [IW-1:0]          last;
  logic [BW-1:0]          beat;

  logic [IW-1:0]          g;
  logic [IW-1:0]          pick_from;
  logic [IW:0]            pick;
  logic [NUM_REQ-1:0]     ready_vec;
  logic                   xfer;
  logic                   release_burst;
  logic [DATA_WIDTH-1:0]  din_mux;

  // First set bit of valid searching upward from from+1 (wrapping); bit
  // 'from' itself is examined last. MSB of the result flags "found".
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                          input logic [IW-1:0]      from);
    logic [IW:0] res;
    int          idx;
    res = '0;
    // Walk from farthest to nearest so the nearest hit overwrites the rest.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(from) + k) % NUM_REQ;
      if (valid[idx]) begin
        res = {1'b1, idx[IW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    for (int i = 0; i < NUM_REQ; i++) begin
      oh[i] = (IW'(i) == idx);
    end
    return oh;
  endfunction

  // Encode the one-hot grant into the granted index g.
  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) begin
        g = IW'(i);
      end else begin
        g = g;
      end
    end
  end

  // Handshake, transfer detection, release and next-pick evaluation.
  always_comb begin
    ready_vec     = grant_vec & {NUM_REQ{~bus.fifo_full}};
    xfer          = |(bus.req_valid & ready_vec);
    release_burst = (state == BURST) &&
                    ((xfer && (beat == BEAT_LAST)) || !bus.req_valid[g]);
    // In BURST the search restarts after g, which is what 'last' becomes on
    // release; g is thus lowest priority and only re-picked when alone.
    if (state == BURST) begin
      pick_from = g;
    end else begin
      pick_from = last;
    end
    pick = rr_pick(bus.req_valid, pick_from);
  end

  // Write-data mux: granted producer's word during a burst, zero when idle.
  always_comb begin
    din_mux = '0;
    if (state == BURST) begin
      din_mux = bus.req_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      din_mux = '0;
    end
  end

  // Arbiter FSM: state, grant, busy, beat counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_vec <= '0;
      busy_flag <= 1'b0;
      last      <= LAST_RST;
      beat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick[IW]) begin
            state     <= BURST;
            busy_flag <= 1'b1;
            grant_vec <= onehot(pick[IW-1:0]);
            beat      <= '0;
          end else begin
            grant_vec <= '0;
            busy_flag <= 1'b0;
          end
        end
        BURST: begin
          if (release_burst) begin
            last <= g;
            beat <= '0;
            if (pick[IW]) begin
              grant_vec <= onehot(pick[IW-1:0]);
            end else begin
              state     <= IDLE;
              busy_flag <= 1'b0;
              grant_vec <= '0;
            end
          end else if (xfer) begin
            beat <= beat + BW'(1);
          end else begin
            beat <= beat;
          end
        end
        default: begin
          state     <= IDLE;
          grant_vec <= '0;
          busy_flag <= 1'b0;
          beat      <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_vec;
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_din   = din_mux;
  assign bus.grant      = grant_vec;
  assign bus.busy       = busy_flag;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Two arbiter instances (BURST_LEN 4 and 1) driven by queue-based producers.
// A behavioural model predicts every output every cycle; directed scenarios
// additionally check the written word sequence against literal lists.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fifo_wr_arbiter_if #(.DATA_WIDTH(4), .NUM_REQ(4)) if0 ();
  fifo_wr_arbiter_if #(.DATA_WIDTH(4), .NUM_REQ(4)) if1 ();

  fifo_wr_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4), .BURST_LEN(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  fifo_wr_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // producer queues per instance/producer
  logic [3:0]  qmem [2][4][32];
  int          qrp  [2][4];
  int          qwp  [2][4];
  logic [3:0]  drv_valid [2];
  logic [15:0] drv_data  [2];
  logic        drv_full  [2];
  logic [3:0]  acc       [2];

  // write log per instance
  int log_val [2][64];
  int log_cyc [2][64];
  int log_n   [2];
  int exq [$];

  // behavioural model: current grant (-1 idle), words in burst, last granted
  typedef struct packed { int cur; int cnt; int last; } mstate_t;
  mstate_t m [2];

  task automatic chk(input string name, input int inst, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d t=%0t", name, inst, got, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [3:0] v, input int from);
    int r;
    r = -1;
    for (int k = 1; k <= 4; k++) begin
      if (r < 0 && v[(from + k) % 4]) r = (from + k) % 4;
    end
    return r;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [3:0] v,
                                         input logic full, input int blen);
    mstate_t n;
    logic wr;
    n = s;
    if (s.cur < 0) begin
      if (v != 4'd0) begin
        n.cur = rr_next(v, s.last);
        n.cnt = 0;
      end
    end else begin
      wr = v[s.cur] && !full;
      if ((wr && (s.cnt + 1 == blen)) || !v[s.cur]) begin
        n.last = s.cur;
        n.cur  = rr_next(v, s.cur);
        n.cnt  = 0;
      end else if (wr) begin
        n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  // model state advance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) m[i] <= '{cur: -1, cnt: 0, last: 3};
    end else begin
      m[0] <= model_step(m[0], drv_valid[0], drv_full[0], 4);
      m[1] <= model_step(m[1], drv_valid[1], drv_full[1], 1);
    end
  end

  task automatic compare_inst(input int inst, input logic [3:0] g_grant, input logic g_busy,
                              input logic [3:0] g_ready, input logic g_wr, input logic [3:0] g_din);
    int ex_grant, ex_ready, ex_wr, ex_din, ex_busy;
    mstate_t s;
    s = m[inst];
    ex_grant = (s.cur < 0) ? 0 : (1 << s.cur);
    ex_busy  = (s.cur < 0) ? 0 : 1;
    ex_ready = drv_full[inst] ? 0 : ex_grant;
    ex_wr    = (s.cur >= 0 && drv_valid[inst][s.cur] && !drv_full[inst]) ? 1 : 0;
    ex_din   = (s.cur < 0) ? 0 : int'(drv_data[inst][s.cur*4 +: 4]);
    chk("grant", inst, int'(g_grant), ex_grant);
    chk("busy", inst, int'(g_busy), ex_busy);
    chk("req_ready", inst, int'(g_ready), ex_ready);
    chk("fifo_wr_en", inst, int'(g_wr), ex_wr);
    chk("fifo_din", inst, int'(g_din), ex_din);
    acc[inst] = drv_valid[inst] & g_ready;
    if (g_wr && log_n[inst] < 64) begin
      log_val[inst][log_n[inst]] = int'(g_din);
      log_cyc[inst][log_n[inst]] = cyc;
      log_n[inst]++;
    end
  endtask

  // per-cycle compare against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      compare_inst(0, if0.grant, if0.busy, if0.req_ready, if0.fifo_wr_en, if0.fifo_din);
      compare_inst(1, if1.grant, if1.busy, if1.req_ready, if1.fifo_wr_en, if1.fifo_din);
    end
  end

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 4; p++) begin
        drv_valid[i][p] = (qrp[i][p] < qwp[i][p]);
        drv_data[i][p*4 +: 4] = drv_valid[i][p] ? qmem[i][p][qrp[i][p]] : 4'h0;
      end
    end
    if0.req_valid = drv_valid[0]; if0.req_data = drv_data[0]; if0.fifo_full = drv_full[0];
    if1.req_valid = drv_valid[1]; if1.req_data = drv_data[1]; if1.fifo_full = drv_full[1];
  endtask

  task automatic push(input int inst, input int p, input logic [3:0] w);
    qmem[inst][p][qwp[inst][p]] = w;
    qwp[inst][p]++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 4; p++)
        if (acc[i][p]) qrp[i][p]++;
    drive();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      log_n[i] = 0;
      acc[i] = 4'd0;
      drv_full[i] = 1'b0;
      for (int p = 0; p < 4; p++) begin
        qrp[i][p] = 0;
        qwp[i][p] = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    clear_all();
    drive();
  endtask

  task automatic drain(input int inst, input int budget);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      pending = (m[inst].cur >= 0);
      for (int p = 0; p < 4; p++) if (qrp[inst][p] < qwp[inst][p]) pending = 1'b1;
      if (pending) begin
        tick();
        n++;
      end
    end
    chk("drain_in_budget", inst, int'(n < budget), 1);
  endtask

  task automatic check_log(input int inst, input string name);
    chk({name, "_len"}, inst, log_n[inst], exq.size());
    for (int k = 0; k < exq.size() && k < log_n[inst]; k++)
      chk(name, inst, log_val[inst][k], exq[k]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog inst=0 got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 0, int'(if0.grant), 0);
    chk("rst_busy", 0, int'(if0.busy), 0);
    chk("rst_ready", 0, int'(if0.req_ready), 0);
    chk("rst_wr", 0, int'(if0.fifo_wr_en), 0);
    chk("rst_din", 0, int'(if0.fifo_din), 0);
    rst_n = 1'b1;

    // S1: producer 0 alone, words 1..6
    for (int k = 1; k <= 6; k++) push(0, 0, 4'(k));
    drive();
    tick();
    chk("s1_grant", 0, int'(if0.grant), 1);
    drain(0, 100);
    exq = {1, 2, 3, 4, 5, 6};
    check_log(0, "s1_log");
    chk("s1_span", 0, log_cyc[0][5] - log_cyc[0][0], 5);

    // S2: all producers, producer i sends value i
    do_reset();
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 8; k++) push(0, p, 4'(p));
    drive();
    drain(0, 200);
    exq.delete();
    for (int k = 0; k < 32; k++) exq.push_back((k / 4) % 4);
    check_log(0, "s2_log");
    chk("s2_span", 0, log_cyc[0][31] - log_cyc[0][0], 31);

    // S3: producer 1 stalled by fifo_full for 3 cycles after its 2nd word
    do_reset();
    for (int k = 1; k <= 6; k++) push(0, 1, 4'(k));
    push(0, 2, 4'hA);
    push(0, 2, 4'hB);
    drive();
    tick();
    chk("s3_grant", 0, int'(if0.grant), 2);
    tick();
    tick();
    drv_full[0] = 1'b1;
    drive();
    chk("s3_beat", 0, int'(dut0.beat), 2);
    repeat (3) begin
      tick();
      chk("s3_beat_hold", 0, int'(dut0.beat), 2);
      chk("s3_grant_hold", 0, int'(if0.grant), 2);
    end
    drv_full[0] = 1'b0;
    drive();
    drain(0, 100);
    exq = {1, 2, 3, 4, 10, 11, 5, 6};
    check_log(0, "s3_log");
    chk("s3_stall_gap", 0, log_cyc[0][2] - log_cyc[0][1], 4);

    // S4: producer 0 drops valid after 2 words, re-asserts while 2 bursts
    do_reset();
    push(0, 0, 4'd1);
    push(0, 0, 4'd2);
    for (int k = 7; k <= 12; k++) push(0, 2, 4'(k));
    drive();
    repeat (4) tick();
    chk("s4_handoff", 0, int'(if0.grant), 4);
    push(0, 0, 4'd13);
    push(0, 0, 4'd14);
    drive();
    drain(0, 100);
    exq = {1, 2, 7, 8, 9, 10, 13, 14, 11, 12};
    check_log(0, "s4_log");
    chk("s4_gap", 0, log_cyc[0][2] - log_cyc[0][1], 2);

    // S5: asynchronous reset mid-burst
    do_reset();
    for (int k = 1; k <= 8; k++) push(0, 0, 4'(k));
    for (int k = 9; k <= 12; k++) push(0, 3, 4'(k));
    drive();
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_grant", 0, int'(if0.grant), 0);
    chk("s5_rst_wr", 0, int'(if0.fifo_wr_en), 0);
    chk("s5_rst_ready", 0, int'(if0.req_ready), 0);
    chk("s5_rst_busy", 0, int'(if0.busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("s5_first", 0, int'(if0.grant), 1);
    drain(0, 100);
    exq = {1, 2, 3, 4, 5, 6, 9, 10, 11, 12, 7, 8};
    check_log(0, "s5_log");

    // S6: BURST_LEN = 1, producers 0 and 2 alternate every cycle
    do_reset();
    for (int k = 1; k <= 4; k++) push(1, 0, 4'(k));
    for (int k = 9; k <= 12; k++) push(1, 2, 4'(k));
    drive();
    tick();
    chk("s6_grant0", 1, int'(if1.grant), 1);
    tick();
    chk("s6_grant2", 1, int'(if1.grant), 4);
    drain(1, 100);
    exq = {1, 9, 2, 10, 3, 11, 4, 12};
    check_log(1, "s6_log");
    chk("s6_span", 1, log_cyc[1][7] - log_cyc[1][0], 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO (the 4-bit x 256 `sync_fifo` family) between `NUM_REQ` producers. Each producer presents a valid/ready word stream. The arbiter grants one producer at a time for a burst of up to `BURST_LEN` words and muxes that producer's data onto the FIFO write port. It respects the FIFO `full` flag and hands the grant to the next producer with no idle cycle.

## Interface
- `DATA_WIDTH`, 4: word width; matches FIFO `din`.
- `NUM_REQ`, 4: number of producers; minimum 2.
- `BURST_LEN`, 4: maximum words per grant; minimum 1.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `req_valid` input, NUM_REQ: bit i high means producer i offers a word.
- `req_data` input, NUM_REQ*DATA_WIDTH: producer i's word is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` output, NUM_REQ: bit i high means producer i's word is accepted this cycle.
- `fifo_full` input, 1: FIFO full flag.
- `fifo_wr_en` output, 1: FIFO write enable.
- `fifo_din` output, DATA_WIDTH: FIFO write data.
- `grant` output, NUM_REQ: one-hot registered grant; all zero when idle.
- `busy` output, 1: high in state BURST.

## Operation
- FSM has two states.
  - IDLE: `grant` = 0.
  - BURST: exactly one `grant` bit is set. The granted index is `g`.
- Registered state:
  - `state`
  - `grant`
  - `last` (index of the last producer granted)
  - `beat` (0..BURST_LEN-1, width max(1, $clog2(BURST_LEN)))
- Combinational outputs:
  - `req_ready[i]` = grant[i] & ~fifo_full.
  - `fifo_wr_en` = |(req_valid & req_ready).
  - `fifo_din` = data of producer `g` when in BURST, else 0.
- A transfer is a cycle with `fifo_wr_en` = 1. The FIFO captures `fifo_din` at that clock edge.
- Round-robin pick: search `req_valid` starting at index `last`+1 (mod NUM_REQ) and take the first set bit. `last` itself has lowest priority.
- IDLE → BURST: when any `req_valid` is set, grant the picked producer and clear `beat`.
- In BURST, a transfer with `beat` < BURST_LEN-1 increments `beat`.
- Release conditions, evaluated at the clock edge:
  - a) a transfer occurs with `beat` == BURST_LEN-1;
  - b) `req_valid[g]` = 0.
- On release:
  - set `last` to `g`;
  - re-pick among the current `req_valid`, with bit `g` excluded under condition a) only when other requesters are valid;
  - if a pick exists, grant it, clear `beat` and stay in BURST; otherwise go to IDLE.
- A lone valid requester is re-granted back-to-back.
- While `fifo_full` = 1, no transfer occurs, and `beat` and `grant` hold.
- Handshake rule for producers: once valid is asserted, it stays asserted with stable data until ready. Dropping valid between words ends that producer's burst.
- Non-granted producers see `req_ready` = 0. Their valid and data are ignored.

## Timing
- Reset (`rst_n` low, takes effect immediately, asynchronously):
  - `state` = IDLE, `grant` = 0, `beat` = 0, `last` = NUM_REQ-1, so producer 0 has first priority.
  - Outputs: `busy` = 0, `req_ready` = 0, `fifo_wr_en` = 0, `fifo_din` = 0.
- Latency from IDLE: `req_valid` seen at edge N gives `grant` after edge N. The first transfer is possible in cycle N+1.
- Handoff between bursts takes 0 idle cycles. A new grant is registered on the same edge as the last beat of the previous burst.
- Sustained throughput is 1 word per cycle while any producer is valid and `fifo_full` = 0.
- `fifo_full` acts combinationally within the same cycle: `fifo_wr_en` is never high while `fifo_full` is high.
- Reset mid-burst: the partially written burst is abandoned and no write is issued. Words already written stay in the FIFO. The arbiter does not reset the FIFO.

## Test plan
- Producer 0 alone, valid for 6 words `1..6`, `fifo_full` = 0:
  - `grant` = 0001 one cycle after valid;
  - `fifo_wr_en` high for 6 consecutive cycles, `fifo_din` = 1,2,3,4,5,6;
  - re-granted after beat 4 with no bubble.
- All 4 producers continuously valid, producer i sending value i:
  - grants in order 0,1,2,3,0;
  - `fifo_din` = 0,0,0,0,1,1,1,1,2,…, with no idle cycles.
- Producer 1 bursting, `fifo_full` high for 3 cycles after its 2nd word:
  - `req_ready`/`fifo_wr_en` low for those 3 cycles;
  - `beat` held at 2;
  - exactly 4 words from producer 1 in total, then handoff.
- Producers 0 and 2 valid; producer 0 drops valid after 2 words:
  - producer 2 granted on the next edge;
  - producer 0 has lowest priority when it re-asserts valid.
- Assert `rst_n` low asynchronously mid-burst (between edges):
  - `grant`/`fifo_wr_en`/`req_ready` go to 0 immediately;
  - after release with producers 0 and 3 valid, producer 0 is granted first.
- BURST_LEN = 1, producers 0 and 2 continuously valid:
  - grants alternate 0,2,0,2, one word each, every cycle.
